// File: rtl/ulaw_pkg.sv
// ulaw_pkg: shared u-law code field positions, widths and types
package ulaw_pkg;
  localparam int SIGN_BIT  = 7;
  localparam int EXP_MSB   = 6;
  localparam int EXP_LSB   = 4;
  localparam int MAN_MSB   = 3;
  localparam int ULAW_BIAS = 33;
  localparam int PCM_W     = 14;
  localparam int CODE_W    = 8;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [PCM_W-1:0]  pcm_t;
endpackage

// File: rtl/ulaw_expand.sv
// ulaw_expand: combinational 8-bit u-law code to 14-bit two's-complement PCM
module ulaw_expand
  import ulaw_pkg::*;
(
  input  code_t code,
  output pcm_t  pcm
);
  logic [2:0]  e;
  logic [3:0]  m;
  logic [12:0] mag;
  assign e   = code[EXP_MSB:EXP_LSB];
  assign m   = code[MAN_MSB:0];
  assign mag = (({8'd0, m, 1'b0} + 13'(ULAW_BIAS)) << e) - 13'(ULAW_BIAS);
  assign pcm = code[SIGN_BIT] ? -{1'b0, mag} : {1'b0, mag};
endmodule

// File: rtl/ulaw_dec_sched.sv
// ulaw_dec_sched: round-robin scheduler sharing one u-law expander across NCH channels
module ulaw_dec_sched
  import ulaw_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [CODE_W*NCH-1:0] in_code,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCM_W-1:0]      out_data,
  output logic [CW-1:0]         out_chan,
  output logic                  busy
);
  logic [CW-1:0] ptr, idx, gnt_idx, s1_chan;
  logic          found, s1_valid, s1_adv, s2_adv, xfer;
  code_t         code_sel, s1_code;
  pcm_t          pcm;
  assign s2_adv = ~out_valid | out_ready;
  assign s1_adv = ~s1_valid | s2_adv;
  // first requesting channel after ptr, wrapping modulo NCH
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx     = (int'(ptr) + i >= NCH) ? CW'(int'(ptr) + i - NCH) : CW'(int'(ptr) + i);
      gnt_idx = (!found && in_valid[idx]) ? idx : gnt_idx;
      found   = found | in_valid[idx];
    end
  end
  // select the granted channel's code
  always_comb begin
    code_sel = '0;
    for (int i = 0; i < NCH; i++)
      code_sel = (gnt_idx == CW'(i)) ? in_code[i*CODE_W +: CODE_W] : code_sel;
  end
  assign in_ready = (rst_n && s1_adv && found) ? NCH'(1) << gnt_idx : '0;
  assign xfer     = |in_ready;
  assign busy     = s1_valid | out_valid;
  ulaw_expand u_expand (
    .code (s1_code),
    .pcm  (pcm)
  );
  // stage 1: capture granted code and channel, advance the pointer on transfer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr      <= CW'(NCH - 1);
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_chan  <= '0;
    end else if (s1_adv) begin
      s1_valid <= xfer;
      ptr      <= xfer ? gnt_idx : ptr;
      s1_code  <= xfer ? code_sel : s1_code;
      s1_chan  <= xfer ? gnt_idx : s1_chan;
    end
  // stage 2: output register holding the expanded sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_data  <= s1_valid ? pcm : out_data;
      out_chan  <= s1_valid ? s1_chan : out_chan;
    end
endmodule

// File: tb/tb_ulaw_dec_sched.sv
// tb_ulaw_dec_sched: directed self-checking bench for ulaw_dec_sched
module tb_ulaw_dec_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_code = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] out_data;
  logic [1:0]  out_chan;
  logic        busy;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  ch_code [4] = '{8'h25, 8'hB3, 8'h4A, 8'hF1};
  logic [7:0]  codes [261];
  int          dir_exp [5] = '{'h0000, 'h3FE2, 'h1F5F, 'h20A1, 'h0000};
  always #5 clk = ~clk;
  ulaw_dec_sched #(.NCH(4), .CW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .busy      (busy)
  );
  function automatic int ulaw(input logic [7:0] c);
    int mag = ((2 * int'(c[3:0]) + 33) << c[6:4]) - 33;
    return c[7] ? (16384 - mag) % 16384 : mag;
  endfunction
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chan_codes();
    in_code = {ch_code[3], ch_code[2], ch_code[1], ch_code[0]};
  endtask
  initial begin
    int rdy_bp [11] = '{1, 2, 4, 0, 0, 0, 8, 1, 2, 4, 8};
    int chn_bp [9]  = '{0, 1, 1, 1, 1, 2, 3, 0, 1};
    in_valid = 4'hF;
    chan_codes();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    codes[0] = 8'h00; codes[1] = 8'h8F; codes[2] = 8'h7F; codes[3] = 8'hFF; codes[4] = 8'h80;
    for (int i = 0; i < 256; i++) codes[5+i] = 8'(i);
    for (int k = 0; k < 263; k++) begin
      @(negedge clk);
      in_valid = k < 261 ? 4'b0001 : 4'b0000;
      in_code  = k < 261 ? {24'd0, codes[k]} : 32'd0;
      #1;
      if (k < 261) check("sweep_rdy", in_ready, 1);
      if (k == 1) check("sweep_latency", out_valid, 0);
      if (k >= 2) begin
        check("sweep_valid", out_valid, 1);
        check("sweep_data", out_data, (k - 2) < 5 ? dir_exp[k-2] : ulaw(codes[k-2]));
      end
    end
    @(negedge clk);
    #1;
    check("drain_valid", out_valid, 0);
    check("drain_busy", busy, 0);
    do_reset();
    in_valid = 4'hF;
    chan_codes();
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rr_grant", in_ready, 1 << (k % 4));
      if (k >= 2) begin
        check("rr_chan", out_chan, (k - 2) % 4);
        check("rr_data", out_data, ulaw(ch_code[(k-2)%4]));
      end
      @(negedge clk);
    end
    in_valid = '0;
    do_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("sparse_grant", in_ready, k % 2 ? 8 : 2);
      if (k >= 2) check("sparse_chan", out_chan, (k - 2) % 2 ? 3 : 1);
      @(negedge clk);
    end
    in_valid = '0;
    do_reset();
    in_valid = 4'hF;
    for (int k = 0; k < 11; k++) begin
      out_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      #1;
      check("bp_grant", in_ready, rdy_bp[k]);
      if (k >= 2) begin
        check("bp_valid", out_valid, 1);
        check("bp_chan", out_chan, chn_bp[k-2]);
        check("bp_data", out_data, ulaw(ch_code[chn_bp[k-2]]));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("post_rst_valid2", out_valid, 0);
    check("post_rst_grant2", in_ready, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
